// File: rtl/bank_timing_fsm.sv
// Per-bank DRAM command FSM: enforces tRCD/tRAS/tWR/tRP/tRFC with down-counters and tracks refresh debt.
// Define BANK_REFRESH_POSTPONE_EN to let refresh yield to traffic until MAX_POSTPONE refreshes are owed.
module bank_timing_fsm #(
    parameter int ROW_W        = 16,
    parameter int COL_W        = 10,
    parameter int T_RCD        = 4,
    parameter int T_RAS        = 10,
    parameter int T_WR         = 5,
    parameter int T_RP         = 4,
    parameter int T_RFC        = 110,
    parameter int T_REFI       = 3900,
    parameter int MAX_POSTPONE = 8,
    localparam int ADDR_W      = (ROW_W > COL_W) ? ROW_W : COL_W,
    localparam int DEBT_W      = $clog2(MAX_POSTPONE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic              req_auto_pre,
    input  logic              wdata_full,
    output logic              cmd_valid,
    input  logic              cmd_ack,
    output logic [2:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [3:0]        bank_state,
    output logic              row_open,
    output logic [ROW_W-1:0]  open_row,
    output logic [DEBT_W-1:0] refresh_debt,
    output logic              refresh_done
);

    localparam int WAIT_MAX = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                              : ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int RAS_W  = $clog2(T_RAS + 1);
    localparam int WR_W   = $clog2(T_WR + 1);
    localparam int REFI_W = $clog2(T_REFI + 1);

`ifdef BANK_REFRESH_POSTPONE_EN
    localparam int DEBT_MAX = MAX_POSTPONE;
`else
    localparam int DEBT_MAX = 1;
`endif

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_IDLE     = 4'd1,
        ST_ACT      = 4'd2,
        ST_ACT_WAIT = 4'd3,
        ST_STANDBY  = 4'd4,
        ST_RD       = 4'd5,
        ST_WR       = 4'd6,
        ST_PRE      = 4'd7,
        ST_PRE_WAIT = 4'd8,
        ST_REF      = 4'd9,
        ST_REF_WAIT = 4'd10
    } state_t;

    state_t state, next_state;

    logic              buf_write;
    logic [ROW_W-1:0]  buf_row;
    logic [COL_W-1:0]  buf_col;
    logic              buf_auto_pre;
    logic              miss_pending;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RAS_W-1:0]  tras_cnt;
    logic [WR_W-1:0]   twr_cnt;
    logic [REFI_W-1:0] refi_cnt;

    logic urgent, debt_pending, xfer, hit, acked, refi_wrap, ref_ack;

    assign urgent       = refresh_debt >= DEBT_W'(DEBT_MAX);
    assign debt_pending = refresh_debt != '0;
    assign req_ready    = (state == ST_IDLE || state == ST_STANDBY) && !urgent
                          && !(req_write && wdata_full);
    assign xfer         = req_valid && req_ready;
    assign hit          = req_row == open_row;
    assign acked        = cmd_valid && cmd_ack;
    assign refi_wrap    = (state != ST_INIT) && (refi_cnt == REFI_W'(T_REFI - 1));
    assign ref_ack      = (state == ST_REF) && acked;
    assign bank_state   = state;

    always_comb begin
        next_state = state;
        cmd_valid  = 1'b0;
        cmd_type   = CMD_NOP;
        cmd_addr   = '0;
        case (state)
            ST_INIT:     if (init_done) next_state = ST_IDLE;
            ST_IDLE: begin
                if (urgent || (debt_pending && !req_valid)) next_state = ST_REF;
                else if (xfer)                              next_state = ST_ACT;
            end
            ST_ACT: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_ACT;
                cmd_addr  = ADDR_W'(buf_row);
                if (cmd_ack) next_state = ST_ACT_WAIT;
            end
            ST_ACT_WAIT: if (wait_cnt == '0) next_state = buf_write ? ST_WR : ST_RD;
            ST_RD, ST_WR: begin
                cmd_valid = 1'b1;
                cmd_type  = (state == ST_WR) ? CMD_WR : CMD_RD;
                cmd_addr  = ADDR_W'(buf_col);
                if (cmd_ack) next_state = buf_auto_pre ? ST_PRE : ST_STANDBY;
            end
            ST_STANDBY: begin
                if (urgent)    next_state = ST_PRE;
                else if (xfer) next_state = hit ? (req_write ? ST_WR : ST_RD) : ST_PRE;
            end
            ST_PRE: begin
                // Hold the precharge back until both the row-active and write-recovery windows close.
                if (tras_cnt == '0 && twr_cnt == '0) begin
                    cmd_valid = 1'b1;
                    cmd_type  = CMD_PRE;
                    if (cmd_ack) next_state = ST_PRE_WAIT;
                end
            end
            ST_PRE_WAIT: begin
                if (wait_cnt == '0) begin
                    if (miss_pending)      next_state = ST_ACT;
                    else if (debt_pending) next_state = ST_REF;
                    else                   next_state = ST_IDLE;
                end
            end
            ST_REF: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_REF;
                if (cmd_ack) next_state = ST_REF_WAIT;
            end
            ST_REF_WAIT: if (wait_cnt == '0) next_state = ST_IDLE;
            default:     next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            buf_write    <= 1'b0;
            buf_row      <= '0;
            buf_col      <= '0;
            buf_auto_pre <= 1'b0;
            miss_pending <= 1'b0;
            wait_cnt     <= '0;
            tras_cnt     <= '0;
            twr_cnt      <= '0;
            refi_cnt     <= '0;
            row_open     <= 1'b0;
            open_row     <= '0;
            refresh_debt <= '0;
            refresh_done <= 1'b0;
        end else begin
            state <= next_state;

            if (xfer) begin
                buf_write    <= req_write;
                buf_row      <= req_row;
                buf_col      <= req_col;
                buf_auto_pre <= req_auto_pre;
            end

            if (state == ST_STANDBY && xfer && !hit)          miss_pending <= 1'b1;
            else if (state == ST_PRE_WAIT && wait_cnt == '0)  miss_pending <= 1'b0;

            if (state == ST_ACT && acked)      wait_cnt <= WAIT_W'(T_RCD - 2);
            else if (state == ST_PRE && acked) wait_cnt <= WAIT_W'(T_RP - 2);
            else if (ref_ack)                  wait_cnt <= WAIT_W'(T_RFC - 2);
            else if (wait_cnt != '0)           wait_cnt <= wait_cnt - 1'b1;

            if (state == ST_ACT && acked) tras_cnt <= RAS_W'(T_RAS - 1);
            else if (tras_cnt != '0)      tras_cnt <= tras_cnt - 1'b1;

            if (state == ST_WR && acked) twr_cnt <= WR_W'(T_WR - 1);
            else if (twr_cnt != '0)      twr_cnt <= twr_cnt - 1'b1;

            if (state == ST_ACT && acked) begin
                row_open <= 1'b1;
                open_row <= buf_row;
            end else if (state == ST_PRE && acked) begin
                row_open <= 1'b0;
            end

            if (state != ST_INIT) refi_cnt <= refi_wrap ? '0 : refi_cnt + 1'b1;

            // A wrap coinciding with a REF ack cancels out; otherwise saturate up or step down.
            if (refi_wrap && !ref_ack) begin
                if (refresh_debt < DEBT_W'(DEBT_MAX)) refresh_debt <= refresh_debt + 1'b1;
            end else if (ref_ack && !refi_wrap && debt_pending) begin
                refresh_debt <= refresh_debt - 1'b1;
            end

            refresh_done <= (state == ST_REF_WAIT) && (wait_cnt == '0);
        end
    end

endmodule

// File: tb/tb_bank_timing_fsm.sv
// Scoreboard bench for bank_timing_fsm: directed requests push expected commands, a monitor checks issued ones.
// Works with or without BANK_REFRESH_POSTPONE_EN defined.
module tb_bank_timing_fsm;

    localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;
`ifdef BANK_REFRESH_POSTPONE_EN
    localparam int URG = 8;
`else
    localparam int URG = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, init_done, req_valid, req_write, req_auto_pre, wdata_full, cmd_ack;
    logic [15:0] req_row;
    logic [9:0]  req_col;
    logic        req_ready, cmd_valid, row_open, refresh_done;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_addr, open_row;
    logic [3:0]  bank_state, refresh_debt;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] a;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bank_timing_fsm dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_row(req_row), .req_col(req_col), .req_auto_pre(req_auto_pre),
        .wdata_full(wdata_full), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .bank_state(bank_state),
        .row_open(row_open), .open_row(open_row), .refresh_debt(refresh_debt),
        .refresh_done(refresh_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted command must match the head of the expected queue.
    always @(negedge clk) begin
        #3;
        if (cmd_valid && cmd_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_cmd: got type %0d addr 0x%0h at cycle %0d, required none",
                         cmd_type, cmd_addr, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (cmd_type !== mon_e.t || cmd_addr !== mon_e.a || (mon_e.c >= 0 && cyc != mon_e.c)) begin
                    errors++;
                    $display("[TB] FAIL cmd: got type %0d addr 0x%0h cycle %0d, required type %0d addr 0x%0h cycle %0d",
                             cmd_type, cmd_addr, cyc, mon_e.t, mon_e.a, mon_e.c);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    task automatic pushExp(input logic [2:0] t, input logic [15:0] a, input int c);
        exp_t e;
        e.t = t;
        e.a = a;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic waitCycles(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    // Presents a request and returns the cycle in which it was accepted (-1 on timeout).
    task automatic applyStimulus(input logic w, input logic [15:0] row, input logic [9:0] col,
                                 input logic ap, output int n);
        @(negedge clk);
        req_write = w; req_row = row; req_col = col; req_auto_pre = ap; req_valid = 1'b1;
        n = -1;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (req_ready) begin
                n = cyc;
                break;
            end
            @(negedge clk);
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_timeout: got no transfer, required transfer within 300 cycles");
            req_valid = 1'b0;
        end else begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drainQueue(input string name);
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #4;
        end
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, bank_state, 0);
        checkOutput({tag, "_cmd_valid"}, cmd_valid, 0);
        checkOutput({tag, "_cmd_type"}, cmd_type, 0);
        checkOutput({tag, "_cmd_addr"}, cmd_addr, 0);
        checkOutput({tag, "_req_ready"}, req_ready, 0);
        checkOutput({tag, "_row_open"}, row_open, 0);
        checkOutput({tag, "_open_row"}, open_row, 0);
        checkOutput({tag, "_debt"}, refresh_debt, 0);
        checkOutput({tag, "_refresh_done"}, refresh_done, 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n1, n2, n3, n4, n5, pre_c, act2, pre_d, s, u, found;
        rst = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_auto_pre = 1'b0;
        wdata_full = 1'b0; cmd_ack = 1'b1; req_row = '0; req_col = '0;

        waitCycles(3);
        checkResetValues("reset");
        @(negedge clk); rst = 1'b0;
        waitCycles(2);
        checkOutput("init_hold_state", bank_state, 0);
        checkOutput("init_hold_ready", req_ready, 0);
        @(negedge clk); init_done = 1'b1;
        waitCycles(1);
        checkOutput("idle_state", bank_state, 1);
        checkOutput("idle_ready", req_ready, 1);

        // Closed-bank read: ACT at N+1, RD at N+5.
        applyStimulus(1'b0, 16'h0012, 10'h005, 1'b0, n1);
        pushExp(C_ACT, 16'h0012, n1 + 1);
        pushExp(C_RD, 16'h0005, n1 + 5);
        drainQueue("drain_read");
        checkOutput("standby_state", bank_state, 4);
        checkOutput("standby_row_open", row_open, 1);
        checkOutput("standby_open_row", open_row, 16'h0012);

        // Page hit goes straight to RD on the next cycle.
        applyStimulus(1'b0, 16'h0012, 10'h007, 1'b0, n2);
        pushExp(C_RD, 16'h0007, n2 + 1);

        // Page miss: PRE waits for tRAS from the first ACT, ACT follows tRP later.
        applyStimulus(1'b0, 16'h0034, 10'h009, 1'b0, n3);
        #1;
        checkOutput("miss_pre_state", bank_state, 7);
        checkOutput("miss_pre_held", cmd_valid, 0);
        pre_c = (n3 + 1 > n1 + 11) ? n3 + 1 : n1 + 11;
        act2  = pre_c + 4;
        pushExp(C_PRE, 16'h0000, pre_c);
        pushExp(C_ACT, 16'h0034, act2);
        pushExp(C_RD, 16'h0009, act2 + 4);
        drainQueue("drain_miss");
        checkOutput("miss_open_row", open_row, 16'h0034);

        // Write with auto-precharge: PRE no earlier than 5 cycles after the WR.
        applyStimulus(1'b1, 16'h0034, 10'h021, 1'b1, n4);
        pre_d = (n4 + 6 > act2 + 10) ? n4 + 6 : act2 + 10;
        pushExp(C_WR, 16'h0021, n4 + 1);
        pushExp(C_PRE, 16'h0000, pre_d);
        drainQueue("drain_write");
        checkOutput("wr_pre_wait_state", bank_state, 8);
        checkOutput("wr_row_closed", row_open, 0);
        waitCycles(3);
        checkOutput("wr_back_idle", bank_state, 1);

        // wdata_full blocks writes but not reads.
        @(negedge clk);
        wdata_full = 1'b1; req_write = 1'b1; req_row = 16'h0056; req_col = 10'h003;
        req_auto_pre = 1'b1; req_valid = 1'b1;
        #1;
        checkOutput("wfull_write_ready", req_ready, 0);
        waitCycles(1);
        checkOutput("wfull_write_ready_2", req_ready, 0);
        checkOutput("wfull_state_idle", bank_state, 1);
        @(negedge clk);
        req_write = 1'b0;
        #1;
        checkOutput("wfull_read_ready", req_ready, 1);
        n5 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        pushExp(C_ACT, 16'h0056, n5 + 1);
        pushExp(C_RD, 16'h0003, n5 + 5);
        pushExp(C_PRE, 16'h0000, n5 + 11);
        drainQueue("drain_wfull_read");
        wdata_full = 1'b0;
        waitCycles(3);
        checkOutput("wfull_back_idle", bank_state, 1);

        // Ack stall: ACT held with stable fields for 20 cycles.
        cmd_ack = 1'b0;
        applyStimulus(1'b0, 16'h0078, 10'h011, 1'b0, n1);
        for (int i = 0; i < 20; i++) begin
            #1;
            checkOutput("stall_valid", cmd_valid, 1);
            checkOutput("stall_type", cmd_type, C_ACT);
            checkOutput("stall_addr", cmd_addr, 16'h0078);
            @(negedge clk);
        end
        s = cyc;
        pushExp(C_ACT, 16'h0078, s);
        pushExp(C_RD, 16'h0011, s + 4);
        cmd_ack = 1'b1;
        drainQueue("drain_stall");
        checkOutput("stall_standby", bank_state, 4);

        // Refresh: wait for urgency, then PRE, REF and a full tRFC.
        found = 0;
        for (int k = 0; k < 40000; k++) begin
            if (refresh_debt == 4'(URG)) begin
                found = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("debt_reached", found, 1);
        u = cyc;
        checkOutput("urgent_debt", refresh_debt, URG);
        checkOutput("urgent_ready", req_ready, 0);
        checkOutput("urgent_state", bank_state, 4);
        pushExp(C_PRE, 16'h0000, u + 1);
        pushExp(C_REF, 16'h0000, u + 5);
        pushExp(C_REF, 16'h0000, -1);
        waitCycles(6);
        checkOutput("ref_debt_dec", refresh_debt, URG - 1);
        waitCycles(u + 114 - cyc);
        checkOutput("ref_wait_last", bank_state, 10);
        checkOutput("ref_done_early", refresh_done, 0);
        waitCycles(1);
        checkOutput("ref_done_pulse", refresh_done, 1);
        checkOutput("ref_done_idle", bank_state, 1);
        waitCycles(1);
        checkOutput("ref_done_one_cycle", refresh_done, 0);

        // Reset in the middle of the next REF_WAIT.
        found = 0;
        for (int k = 0; k < 5000; k++) begin
            if (bank_state == 4'd10) begin
                found = 1;
                break;
            end
            waitCycles(1);
        end
        checkOutput("second_ref_wait", found, 1);
        waitCycles(20);
        @(negedge clk);
        rst = 1'b1;
        waitCycles(1);
        checkResetValues("midreset");
        waitCycles(3);
        checkOutput("midreset_no_cmd", cmd_valid, 0);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_timing_fsm.md
# bank_timing_fsm

Parametrised per-bank controller, successor to the fixed bank state machine. It accepts row/column requests from the global controller and issues ACT/RD/WR/PRE/REF commands to the command scheduler over a valid/ack handshake. It enforces tRCD, tRAS, tWR, tRP and tRFC internally with down-counters, and postpones refresh under load through a bounded refresh-debt counter. One instance exists per bank, between the request dispatcher and the command scheduler.

## Interface
- ROW_W, 16, row address width
- COL_W, 10, column address width
- T_RCD / T_RAS / T_WR / T_RP / T_RFC, 4 / 10 / 5 / 4 / 110, timing in clk cycles; each must be ≥2
- T_REFI, 3900, refresh interval in cycles
- MAX_POSTPONE, 8, debt level at which refresh becomes urgent (≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- init_done  in  1  power-up init complete
- req_valid / req_ready  in / out  1  request handshake; transfer when both are high
- req_write  in  1  1 = write, 0 = read
- req_row  in  ROW_W, req_col  in  COL_W, req_auto_pre  in  1  request fields
- wdata_full  in  1  write-data FIFO full; blocks write acceptance only
- cmd_valid  out  1, cmd_ack  in  1  command handshake to the scheduler
- cmd_type  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
- cmd_addr  out  max(ROW_W,COL_W)  row for ACT, column for RD/WR, 0 otherwise
- bank_state  out  4  current state encoding
- row_open  out  1, open_row  out  ROW_W  open-page status
- refresh_debt  out  $clog2(MAX_POSTPONE+1)  pending refreshes
- refresh_done  out  1  one-cycle pulse at the end of tRFC

## Operation
- States: INIT, IDLE, ACT, ACT_WAIT, STANDBY, RD, WR, PRE, PRE_WAIT, REF, REF_WAIT.
- **Command states** (ACT, RD, WR, PRE, REF):
  - cmd_valid = 1 and cmd_type is set.
  - The state advances only on cmd_ack.
  - cmd_valid is held with stable fields until ack.
- **req_ready** = (IDLE or STANDBY) and !urgent and !(req_write and wdata_full). Requests are latched into a request buffer on transfer.
- **urgent** = refresh_debt ≥ MAX_POSTPONE.
- **INIT**: go to IDLE when init_done.
- **IDLE**:
  - Go to REF if urgent, or if debt > 0 and !req_valid.
  - Otherwise a transfer goes to ACT.
- **ACT**:
  - On ack: latch open_row and set row_open.
  - Load the tRAS counter with T_RAS-1 and the wait counter with T_RCD-2.
  - Go to ACT_WAIT.
- **ACT_WAIT**: when the wait counter = 0, go to RD or WR per the buffered request.
- **RD / WR**:
  - On ack, WR loads the tWR counter with T_WR-1.
  - Go to PRE if auto_pre, otherwise STANDBY.
- **STANDBY**:
  - urgent → PRE.
  - Transfer with req_row == open_row (hit) → RD or WR directly.
  - Transfer with a miss → PRE, with the request kept pending.
  - With no transfer and debt > 0, stay in STANDBY; precharge only when urgent.
- **PRE**:
  - cmd_valid is asserted only when both the tRAS and tWR counters are 0.
  - On ack: clear row_open, load the wait counter with T_RP-2, go to PRE_WAIT.
- **PRE_WAIT**: at counter = 0, go to ACT if a miss request is pending; else REF if debt > 0; else IDLE.
- **REF**: on ack, decrement debt, load the wait counter with T_RFC-2, go to REF_WAIT.
- **REF_WAIT**: at counter = 0, go to IDLE and pulse refresh_done.
- **Refresh interval**:
  - The tREFI counter runs 0..T_REFI-1 from INIT exit.
  - On wrap, debt increments, saturating at MAX_POSTPONE.
  - A simultaneous increment and REF-ack decrement leaves debt unchanged.
- **Counter width**: tRAS and tWR counters saturate at 0. All counters are $clog2(max+1) bits wide.

## Timing
- Reset values:
  - bank_state = INIT.
  - cmd_valid = 0, cmd_type = 0, cmd_addr = 0.
  - req_ready = 0, row_open = 0, open_row = 0.
  - refresh_debt = 0, refresh_done = 0.
  - All counters = 0.
- Reset mid-operation abandons any in-flight command with no further cmd_valid.
- With immediate ack, a transfer at cycle N gives ACT at N+1 and RD/WR at N+1+T_RCD.
- Spacing with immediate ack:
  - PRE→ACT = T_RP.
  - REF→next command = T_RFC.
  - ACT→PRE ≥ T_RAS.
  - WR→PRE ≥ T_WR.
- A hit in STANDBY at cycle N gives RD/WR at N+1.
- An ack stall extends the current state. Timing counters keep decrementing during the stall.

## Configuration
- `BANK_REFRESH_POSTPONE_EN` defined: debt accumulates to MAX_POSTPONE, and pending refresh yields to requests until urgent.
- Undefined: urgent = debt ≥ 1. A refresh is forced on every tREFI wrap and MAX_POSTPONE is ignored.

## Test plan
- Read, closed bank, ack tied high, defaults:
  - rst released, init_done, read row 0x12 col 0x5 with auto_pre = 0.
  - Expect ACT 0x12 at N+1, RD 0x5 at N+5, then STANDBY with open_row = 0x12.
- Page hit and miss:
  - After the above, read row 0x12 → RD on the next cycle.
  - Then read row 0x34 → PRE held until 10 cycles after ACT, then ACT 0x34 exactly 4 cycles after PRE.
- Write recovery: a write with auto_pre = 1 gives a PRE issued ≥5 cycles after the WR ack.
- wdata_full = 1:
  - A write request sees req_ready = 0.
  - A read request is accepted the same cycle.
- Refresh postponement (macro on):
  - Continuous traffic for 8×T_REFI gives debt 8, urgent, and req_ready = 0.
  - Then PRE and REF are issued, REF_WAIT lasts 110 cycles, and refresh_done pulses.
- Ack stall and reset:
  - Hold cmd_ack = 0 for 20 cycles in ACT → cmd fields remain stable.
  - Assert rst in REF_WAIT → all outputs return to reset values on the next cycle.
